// File: rtl/number_entry.sv
// Keypad number builder: turns digit/minus/enter/clear strobes into a signed
// two's-complement value with a sign code, a commit pulse and entry status.
module number_entry #(
    parameter int unsigned WIDTH      = 25,
    parameter int unsigned MAX_DIGITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             minus_key,
    input  logic             enter_key,
    input  logic             clear_key,
    output logic [WIDTH-1:0] num,
    output logic [1:0]       sign,
    output logic             num_valid,
    output logic             overflow,
    output logic [2:0]       digit_count
);

    localparam int unsigned MAG_W   = WIDTH - 1;
    localparam logic [2:0]  MAX_CNT = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [MAG_W-1:0]   mag;
    logic               neg;
    logic               commit_pend;
    logic               digit_ok;
    logic [MAG_W-1:0]   mag_next;

    // Decimal digit strobe qualification; codes 10-15 are not digits.
    assign digit_ok = digit_valid && (digit <= 4'd9);

    // Shift-in of one decimal digit: mag*10 + digit, bounded by MAX_DIGITS.
    always_comb begin
        mag_next = MAG_W'(mag << 3) + MAG_W'(mag << 1) + MAG_W'(digit);
    end

    // Entry state machine, magnitude accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mag         <= '0;
            neg         <= 1'b0;
            commit_pend <= 1'b0;
            num         <= '0;
            sign        <= 2'd0;
            num_valid   <= 1'b0;
            overflow    <= 1'b0;
            digit_count <= 3'd0;
        end else begin
            // Output stage trails the accumulator by one edge so the commit
            // pulse lines up with the final value.
            commit_pend <= 1'b0;
            num_valid   <= commit_pend;
            num         <= neg ? (~{1'b0, mag} + WIDTH'(1)) : {1'b0, mag};
            sign        <= {1'b0, neg};

            if (clear_key) begin
                mag         <= '0;
                neg         <= 1'b0;
                overflow    <= 1'b0;
                digit_count <= 3'd0;
                state       <= IDLE;
            end else if (enter_key) begin
                if (state != DONE) begin
                    commit_pend <= 1'b1;
                    state       <= DONE;
                end
            end else if (minus_key) begin
                if (state == DONE) begin
                    mag         <= '0;
                    neg         <= 1'b1;
                    overflow    <= 1'b0;
                    digit_count <= 3'd0;
                    state       <= ENTRY;
                end else if (digit_count == 3'd0) begin
                    neg   <= ~neg;
                    state <= ENTRY;
                end
            end else if (digit_ok) begin
                if (state == DONE) begin
                    mag         <= MAG_W'(digit);
                    neg         <= 1'b0;
                    overflow    <= 1'b0;
                    digit_count <= (digit != 4'd0) ? 3'd1 : 3'd0;
                    state       <= ENTRY;
                end else if (digit_count < MAX_CNT) begin
                    mag   <= mag_next;
                    state <= ENTRY;
                    if (mag_next != '0) begin
                        digit_count <= digit_count + 3'd1;
                    end
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_number_entry.sv
// Self-checking bench for number_entry: directed scenarios plus random key
// streams, scored against an integer-arithmetic model of the keypad entry.
module tb_number_entry;

    localparam int unsigned WIDTH = 25;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             digit_valid = 1'b0;
    logic [3:0]       digit = 4'd0;
    logic             minus_key = 1'b0;
    logic             enter_key = 1'b0;
    logic             clear_key = 1'b0;
    logic [WIDTH-1:0] num;
    logic [1:0]       sign;
    logic             num_valid;
    logic             overflow;
    logic [2:0]       digit_count;

    number_entry #(.WIDTH(WIDTH), .MAX_DIGITS(7)) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .minus_key(minus_key), .enter_key(enter_key), .clear_key(clear_key),
        .num(num), .sign(sign), .num_valid(num_valid), .overflow(overflow),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [WIDTH-1:0] num;
        logic [1:0]       sign;
        int               due;
    } exp_t;
    exp_t sb[$];

    // Reference model: the entry as a plain decimal integer and flags.
    int m_mag = 0;
    bit m_neg = 0;
    bit m_ovf = 0;
    bit m_done = 0;

    function automatic int ndigits(input int m);
        int n = 0;
        while (m > 0) begin
            m = m / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] m_value();
        int v = m_neg ? -m_mag : m_mag;
        return WIDTH'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_apply(input bit clr, input bit ent, input bit mns,
                               input bit dv, input int d);
        exp_t e;
        if (clr) begin
            m_mag = 0; m_neg = 0; m_ovf = 0; m_done = 0;
        end else if (ent) begin
            if (!m_done) begin
                m_done = 1;
                e.num  = m_value();
                e.sign = {1'b0, m_neg};
                e.due  = cyc + 2;
                sb.push_back(e);
            end
        end else if (mns) begin
            if (m_done) begin
                m_mag = 0; m_neg = 1; m_ovf = 0; m_done = 0;
            end else if (ndigits(m_mag) == 0) begin
                m_neg = !m_neg;
            end
        end else if (dv && d <= 9) begin
            if (m_done) begin
                m_mag = d; m_neg = 0; m_ovf = 0; m_done = 0;
            end else if (ndigits(m_mag) < 7) begin
                m_mag = m_mag * 10 + d;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // Drive one cycle of key strobes and advance the model in step.
    task automatic key(input bit clr, input bit ent, input bit mns,
                       input bit dv, input int d);
        @(negedge clk);
        clear_key   = clr;
        enter_key   = ent;
        minus_key   = mns;
        digit_valid = dv;
        digit       = 4'(d);
        model_apply(clr, ent, mns, dv, d);
    endtask

    task automatic dig(input int d);
        key(0, 0, 0, 1, d);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        clear_key = 0; enter_key = 0; minus_key = 0; digit_valid = 0; digit = 4'd0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic chk_state(input string tag);
        idle(2);
        chk({tag, ".num"}, 32'(num), 32'(m_value()));
        chk({tag, ".sign"}, 32'(sign), {31'd0, m_neg});
        chk({tag, ".digit_count"}, 32'(digit_count), 32'(ndigits(m_mag)));
        chk({tag, ".overflow"}, 32'(overflow), {31'd0, m_ovf});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".num"}, 32'(num), 32'd0);
        chk({tag, ".sign"}, 32'(sign), 32'd0);
        chk({tag, ".num_valid"}, 32'(num_valid), 32'd0);
        chk({tag, ".overflow"}, 32'(overflow), 32'd0);
        chk({tag, ".digit_count"}, 32'(digit_count), 32'd0);
    endtask

    // Monitor: every num_valid pulse must match the next queued commit, on time.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("missing_num_valid", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (num_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_num_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("commit.cycle", 32'(cyc), 32'(e.due));
                    chk("commit.num", 32'(num), 32'(e.num));
                    chk("commit.sign", 32'(sign), 32'(e.sign));
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // 1,2,3 enter.
        dig(1); dig(2); dig(3); key(0, 1, 0, 0, 0);
        chk_state("p123");
        chk("p123.literal", 32'(num), 32'd123);

        // -405 enter, then a second enter that must not pulse.
        key(1, 0, 0, 0, 0);
        key(0, 0, 1, 0, 0); dig(4); dig(0); dig(5); key(0, 1, 0, 0, 0);
        chk_state("m405");
        chk("m405.literal", 32'(num), 32'h01FFFE6B);
        key(0, 1, 0, 0, 0);
        chk_state("m405.reenter");

        // Lone minus commits zero with sign; minus after a digit is ignored.
        key(1, 0, 0, 0, 0);
        key(0, 0, 1, 0, 0); key(0, 1, 0, 0, 0);
        chk_state("lone_minus");
        chk("lone_minus.sign", 32'(sign), 32'd1);
        key(1, 0, 0, 0, 0);
        dig(7); key(0, 0, 1, 0, 0);
        chk_state("minus_late");

        // Nine 9s saturate at seven digits with overflow; clear empties.
        key(1, 0, 0, 0, 0);
        repeat (9) dig(9);
        chk_state("ovf");
        chk("ovf.literal", 32'(num), 32'd9999999);
        key(1, 0, 0, 0, 0);
        chk_state("ovf.clear");

        // Leading zeros then minus; new digit in DONE starts fresh entry.
        dig(0); dig(0); key(0, 0, 1, 0, 0); dig(8); key(0, 1, 0, 0, 0);
        chk_state("lead0");
        dig(5);
        chk_state("restart");
        dig(12);
        chk_state("ignored_code");

        // Priority: clear beats enter and digit in the same cycle.
        dig(3); dig(1);
        key(1, 1, 1, 1, 6);
        chk_state("priority");

        // Asynchronous reset between edges mid-entry.
        dig(4); dig(2);
        idle(2);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        m_mag = 0; m_neg = 0; m_ovf = 0; m_done = 0;
        chk_state("post_rst");

        // Random key streams, back to back.
        for (int i = 0; i < 800; i++) begin
            int r = $urandom_range(0, 99);
            bit clr = (r < 3);
            bit ent = (r >= 3 && r < 13);
            bit mns = (r >= 13 && r < 21);
            bit dv  = (r >= 21 && r < 85);
            int d   = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            if ($urandom_range(0, 19) == 0) begin
                clr = clr | ($urandom_range(0, 3) == 0);
                ent = ent | $urandom_range(0, 1);
                mns = mns | $urandom_range(0, 1);
                dv  = dv  | $urandom_range(0, 1);
            end
            key(clr, ent, mns, dv, d);
            if (i % 16 == 15) chk_state("rand");
        end

        idle(4);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
